game_ctrl: RTL and testbench

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/game_pkg.sv | 40 ++++
 rtl/level_rom.sv | 32 +++
 rtl/game_ctrl.sv | 148 ++++++++++++++
 tb/tb_game_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the whack-a-mole game controller: FSM encodings,
// level table constants and the per-level configuration record.
// Latency: n/a (constants only). Backpressure: n/a.
package game_pkg;

    localparam int NUM_LEVELS_DEF   = 4;
    localparam int CFG_W            = 27;   // interval / duration width
    localparam int MOLE_W           = 3;    // molenum width
    localparam int HITS_W           = 3;    // round_hits / pass_hits width
    localparam int LEVEL_W          = 2;    // level index width
    localparam int ACK_RETRY_CYCLES = 4;    // WAIT_ACK cycles before re-launch

    // Controller states
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LOAD     = 3'd1;
    localparam logic [2:0] ST_LAUNCH   = 3'd2;
    localparam logic [2:0] ST_WAIT_ACK = 3'd3;
    localparam logic [2:0] ST_PLAY     = 3'd4;
    localparam logic [2:0] ST_JUDGE    = 3'd5;
    localparam logic [2:0] ST_OVER     = 3'd6;

    typedef struct packed {
        logic [CFG_W-1:0]  interval;
        logic [CFG_W-1:0]  duration;
        logic [MOLE_W-1:0] molenum;
        logic [HITS_W-1:0] pass_hits;
    } level_cfg_t;

    // Level table: each level is faster, shows moles for less time and
    // demands more hits to advance.
    localparam level_cfg_t LVL0_CFG = '{interval: 27'd50_000_000, duration: 27'd75_000_000,
                                        molenum: 3'd5, pass_hits: 3'd3};
    localparam level_cfg_t LVL1_CFG = '{interval: 27'd40_000_000, duration: 27'd50_000_000,
                                        molenum: 3'd6, pass_hits: 3'd4};
    localparam level_cfg_t LVL2_CFG = '{interval: 27'd30_000_000, duration: 27'd35_000_000,
                                        molenum: 3'd7, pass_hits: 3'd5};
    localparam level_cfg_t LVL3_CFG = '{interval: 27'd20_000_000, duration: 27'd25_000_000,
                                        molenum: 3'd7, pass_hits: 3'd6};

endpackage

// File: rtl/level_rom.sv
// Level table lookup: maps a level index to its round configuration.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows level directly.
module level_rom
    import game_pkg::*;
(
    input  logic [LEVEL_W-1:0] level,
    output logic [CFG_W-1:0]   interval,
    output logic [CFG_W-1:0]   duration,
    output logic [MOLE_W-1:0]  molenum,
    output logic [HITS_W-1:0]  pass_hits
);

    level_cfg_t cfg;

    // Select the table entry for the requested level
    always_comb begin
        cfg = LVL0_CFG;
        case (level)
            2'd0:    cfg = LVL0_CFG;
            2'd1:    cfg = LVL1_CFG;
            2'd2:    cfg = LVL2_CFG;
            default: cfg = LVL3_CFG;
        endcase
    end

    assign interval  = cfg.interval;
    assign duration  = cfg.duration;
    assign molenum   = cfg.molenum;
    assign pass_hits = cfg.pass_hits;

endmodule

// File: rtl/game_ctrl.sv
// Game controller: sequences levels, launches rounds, counts hits and judges pass/fail.
// Latency: round_start 2 cycles after start; outputs are registers or state decodes.
// Backpressure: re-pulses round_start every 5 cycles until the sequencer drops round_over.
module game_ctrl
    import game_pkg::*;
#(
    parameter int NUM_LEVELS = NUM_LEVELS_DEF,
    parameter int SCORE_W    = 8
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               round_over,
    input  logic               hit_success,
    output logic               round_start,
    output logic [CFG_W-1:0]   interval,
    output logic [CFG_W-1:0]   duration,
    output logic [MOLE_W-1:0]  molenum,
    output logic [LEVEL_W-1:0] level,
    output logic [HITS_W-1:0]  round_hits,
    output logic [SCORE_W-1:0] score,
    output logic               game_over,
    output logic               game_win
);

    localparam logic [LEVEL_W-1:0] LAST_LVL   = LEVEL_W'(NUM_LEVELS - 1);
    localparam logic [1:0]         RETRY_LAST = 2'(ACK_RETRY_CYCLES - 1);
    localparam logic [HITS_W-1:0]  HITS_MAX   = '1;
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

    logic [2:0]         state;
    logic [2:0]         state_nxt;
    logic [1:0]         retry_cnt;

    logic [CFG_W-1:0]   rom_interval;
    logic [CFG_W-1:0]   rom_duration;
    logic [MOLE_W-1:0]  rom_molenum;
    logic [HITS_W-1:0]  rom_pass_hits;

    logic               new_game;
    logic               round_pass;
    logic               last_level;

    level_rom u_level_rom (
        .level     (level),
        .interval  (rom_interval),
        .duration  (rom_duration),
        .molenum   (rom_molenum),
        .pass_hits (rom_pass_hits)
    );

    // start is only honoured while no game is running
    assign new_game   = start && ((state == ST_IDLE) || (state == ST_OVER));
    assign round_pass = (round_hits >= rom_pass_hits);
    assign last_level = (level == LAST_LVL);

    assign round_start = (state == ST_LAUNCH);
    assign game_over   = (state == ST_OVER);

    // Next-state selection
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_OVER: begin
                if (start) state_nxt = ST_LOAD;
            end
            ST_LOAD:   state_nxt = ST_LAUNCH;
            ST_LAUNCH: state_nxt = ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                if (!round_over)                   state_nxt = ST_PLAY;
                else if (retry_cnt == RETRY_LAST)  state_nxt = ST_LAUNCH;
            end
            ST_PLAY: begin
                if (round_over) state_nxt = ST_JUDGE;
            end
            ST_JUDGE: begin
                if (!round_pass || last_level) state_nxt = ST_OVER;
                else                           state_nxt = ST_LOAD;
            end
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Count consecutive WAIT_ACK cycles with the sequencer still idle
    always_ff @(posedge clk) begin
        if (rst) begin
            retry_cnt <= 2'd0;
        end else if ((state == ST_WAIT_ACK) && round_over) begin
            retry_cnt <= (retry_cnt == RETRY_LAST) ? 2'd0 : retry_cnt + 2'd1;
        end else begin
            retry_cnt <= 2'd0;
        end
    end

    // Round configuration is captured once per round, on the LOAD edge
    always_ff @(posedge clk) begin
        if (rst) begin
            interval <= LVL0_CFG.interval;
            duration <= LVL0_CFG.duration;
            molenum  <= LVL0_CFG.molenum;
        end else if (state == ST_LOAD) begin
            interval <= rom_interval;
            duration <= rom_duration;
            molenum  <= rom_molenum;
        end
    end

    // Game statistics: level progression, hit counting and the win flag
    always_ff @(posedge clk) begin
        if (rst) begin
            level      <= '0;
            round_hits <= '0;
            score      <= '0;
            game_win   <= 1'b0;
        end else if (new_game) begin
            level      <= '0;
            round_hits <= '0;
            score      <= '0;
            game_win   <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    round_hits <= '0;
                end
                ST_PLAY: begin
                    if (hit_success) begin
                        if (round_hits != HITS_MAX) round_hits <= round_hits + 1'b1;
                        if (score != SCORE_MAX)     score      <= score + 1'b1;
                    end
                end
                ST_JUDGE: begin
                    if (round_pass) begin
                        if (last_level) game_win <= 1'b1;
                        else            level    <= level + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: randomized games against a game-level outcome model.
// Latency: expects round_start 2 cycles after start/LOAD and every 5 cycles on retry.
// Backpressure: bench plays the round sequencer, holding round_over to force re-launches.
module tb_game_ctrl;

    localparam int SCORE_W   = 8;
    localparam int SCORE_CAP = (1 << SCORE_W) - 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               round_over;
    logic               hit_success;
    logic               round_start;
    logic [26:0]        interval;
    logic [26:0]        duration;
    logic [2:0]         molenum;
    logic [1:0]         level;
    logic [2:0]         round_hits;
    logic [SCORE_W-1:0] score;
    logic               game_over;
    logic               game_win;

    int checks   = 0;
    int failures = 0;

    // Reference level table
    int ref_interval [4] = '{50_000_000, 40_000_000, 30_000_000, 20_000_000};
    int ref_duration [4] = '{75_000_000, 50_000_000, 35_000_000, 25_000_000};
    int ref_molenum  [4] = '{5, 6, 7, 7};
    int ref_pass     [4] = '{3, 4, 5, 6};

    game_ctrl #(.NUM_LEVELS(4), .SCORE_W(SCORE_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .round_over  (round_over),
        .hit_success (hit_success),
        .round_start (round_start),
        .interval    (interval),
        .duration    (duration),
        .molenum     (molenum),
        .level       (level),
        .round_hits  (round_hits),
        .score       (score),
        .game_over   (game_over),
        .game_win    (game_win)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Advance one cycle; outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string pfx);
        check_val({pfx, "_round_start"}, round_start, 0);
        check_val({pfx, "_interval"},    interval,    50_000_000);
        check_val({pfx, "_duration"},    duration,    75_000_000);
        check_val({pfx, "_molenum"},     molenum,     5);
        check_val({pfx, "_level"},       level,       0);
        check_val({pfx, "_round_hits"},  round_hits,  0);
        check_val({pfx, "_score"},       score,       0);
        check_val({pfx, "_game_over"},   game_over,   0);
        check_val({pfx, "_game_win"},    game_win,    0);
    endtask

    // Act as the round sequencer for one round; entered in the round_start cycle
    task automatic play_round(input int lvl, input int hits, input int retries,
                              input int prev_sc, input int exp_sc);
        bit coin;
        int n_sep;
        int quiet_pulses;
        check_val("cfg_interval", interval,   ref_interval[lvl]);
        check_val("cfg_duration", duration,   ref_duration[lvl]);
        check_val("cfg_molenum",  molenum,    ref_molenum[lvl]);
        check_val("round_level",  level,      lvl);
        check_val("round_hits_0", round_hits, 0);
        for (int r = 0; r < retries; r++) begin
            round_over   = 1'b1;
            quiet_pulses = 0;
            repeat (4) begin
                hit_success = 1'($urandom_range(0, 1));
                step();
                if (round_start) quiet_pulses++;
            end
            check_val("retry_quiet", quiet_pulses, 0);
            hit_success = 1'b0;
            step();
            check_val("retry_pulse", round_start, 1);
        end
        // Acknowledge; stray hits before PLAY must be ignored
        round_over  = 1'b0;
        hit_success = 1'($urandom_range(0, 1));
        step();
        hit_success = 1'($urandom_range(0, 1));
        step();
        hit_success = 1'b0;
        check_val("stray_hits_ignored", round_hits, 0);
        check_val("score_at_play",      score,      prev_sc);
        coin  = (hits > 0) && ($urandom_range(0, 1) == 1);
        n_sep = coin ? hits - 1 : hits;
        for (int i = 0; i < n_sep; i++) begin
            hit_success = 1'b1;
            start       = ($urandom_range(0, 7) == 0);
            step();
            hit_success = 1'b0;
            start       = 1'b0;
            repeat ($urandom_range(0, 2)) step();
        end
        // End the round, optionally with the final hit on the same edge
        round_over  = 1'b1;
        hit_success = coin;
        step();
        hit_success = 1'b0;
        check_val("judge_round_hits", round_hits, imin(hits, 7));
        check_val("judge_score",      score,      exp_sc);
        start = ($urandom_range(0, 3) == 0);
        step();
        start = 1'b0;
    endtask

    // Idle in OVER with stray hits; results must hold
    task automatic over_idle(input int sc, input bit win, input int lvl);
        repeat (6) begin
            hit_success = 1'($urandom_range(0, 1));
            step();
        end
        hit_success = 1'b0;
        step();
        check_val("over_score_hold", score,     sc);
        check_val("over_level_hold", level,     lvl);
        check_val("over_win_hold",   game_win,  win);
        check_val("over_state_hold", game_over, 1);
    endtask

    // Play a full game; outcome predicted from the level rules alone
    task automatic play_game(input int h0, input int h1, input int h2, input int h3,
                             input int rt0);
        int  hits [4];
        int  sc;
        int  prev;
        bit  pass;
        hits = '{h0, h1, h2, h3};
        sc   = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        check_val("load_no_pulse",  round_start, 0);
        step();
        check_val("start_to_pulse", round_start, 1);
        for (int l = 0; l < 4; l++) begin
            prev = sc;
            sc   = imin(sc + hits[l], SCORE_CAP);
            pass = (imin(hits[l], 7) >= ref_pass[l]);
            play_round(l, hits[l], (l == 0) ? rt0 : int'($urandom_range(0, 1)), prev, sc);
            if (!pass || l == 3) begin
                check_val("end_game_over", game_over, 1);
                check_val("end_game_win",  game_win,  pass);
                check_val("end_level",     level,     l);
                check_val("end_score",     score,     sc);
                over_idle(sc, pass, l);
                break;
            end
            check_val("midgame_not_over", game_over,   0);
            check_val("reload_no_pulse",  round_start, 0);
            step();
            check_val("next_round_pulse", round_start, 1);
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rst         = 1'b1;
        start       = 1'b0;
        round_over  = 1'b1;
        hit_success = 1'b0;
        step();
        step();
        check_reset_values("reset");
        rst = 1'b0;
        step();

        // Clean win through every level
        play_game(3, 4, 5, 6, 0);
        // Lose on the first level
        play_game(2, 9, 9, 9, 0);
        // Sequencer slow to acknowledge: repeated launches
        play_game(3, 4, 5, 6, 3);
        // Round hit saturation and score saturation
        play_game(70, 70, 70, 70, 1);
        // Randomized games, mostly passing
        for (int g = 0; g < 20; g++) begin
            play_game($urandom_range(1, 9), $urandom_range(2, 9),
                      $urandom_range(3, 9), $urandom_range(4, 9),
                      $urandom_range(0, 2));
        end

        // Reset in the middle of a round with score 4
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check_val("rst_test_pulse", round_start, 1);
        round_over = 1'b0;
        step();
        step();
        repeat (4) begin
            hit_success = 1'b1;
            step();
        end
        hit_success = 1'b0;
        check_val("pre_rst_score", score, 4);
        rst         = 1'b1;
        hit_success = 1'b1;
        step();
        rst         = 1'b0;
        hit_success = 1'b0;
        check_reset_values("midplay_rst");
        round_over = 1'b1;
        seen = 0;
        repeat (8) begin
            step();
            if (round_start || game_over) seen++;
        end
        check_val("idle_after_rst", seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
